// File: rtl/uart_rib_master.sv
// UART-to-RIB debug initiator: decodes 'W'/'R' frames from i_rx, runs one RIB
// transaction per frame and streams the reply bytes. Optional macro: UART_RIB_TIMEOUT_EN.
module uart_rib_master #(
  parameter int CLK_DIV = 868,
  parameter int TIMEOUT = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic [31:0] o_ribm_addr,
  output logic        o_ribm_wrcs,
  output logic [3:0]  o_ribm_mask,
  output logic [31:0] o_ribm_wdata,
  input  logic [31:0] i_ribm_rdata,
  output logic        o_ribm_req,
  input  logic        i_ribm_gnt,
  input  logic        i_ribm_rsp,
  output logic        o_ribm_rdy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy,
  output logic        o_frm_err
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]     CMD_WR    = 8'h57;
  localparam logic [7:0]     CMD_RD    = 8'h52;
  localparam logic [7:0]     ACK_BYTE  = 8'h4B;

  if (CLK_DIV < 4 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_rib_master: CLK_DIV must be >= 4 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_REQ, P_RSP, P_REPLY} p_state_e;

  // [0] first sync flop, [1] synchronised line, [2] previous synchronised value
  logic [2:0]  rx_sync_q, rx_sync_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        byte_vld_q, byte_vld_d;
  logic        frm_err_q, frm_err_d;

  p_state_e    p_state_q, p_state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;
`ifdef UART_RIB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  logic rx_s, rx_fall;
  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

  // UART receiver
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    rx_sync_d  = {rx_sync_q[1:0], i_rx};
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      default: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        byte_vld_d = rx_s;
        frm_err_d  = ~rx_s;
      end
    endcase
  end

  // Frame parser and RIB / reply sequencing
  always_comb begin
    p_state_d = p_state_q;
    bcnt_d    = bcnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
`ifdef UART_RIB_TIMEOUT_EN
    tmo_d     = '0;
`endif
    case (p_state_q)
      P_IDLE: if (byte_vld_q && (rx_shift_q == CMD_WR || rx_shift_q == CMD_RD)) begin
        wr_d      = (rx_shift_q == CMD_WR);
        bcnt_d    = '0;
        p_state_d = P_ADDR;
      end
      P_ADDR: if (byte_vld_q) begin
        addr_d[{bcnt_q, 3'b000} +: 8] = rx_shift_q;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) p_state_d = wr_q ? P_DATA : P_REQ;
      end
      P_DATA: if (byte_vld_q) begin
        wdata_d[{bcnt_q, 3'b000} +: 8] = rx_shift_q;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) p_state_d = P_REQ;
      end
      P_REQ: if (i_ribm_gnt) p_state_d = P_RSP;
      P_RSP: if (i_ribm_rsp) begin
        if (!wr_q) rdata_d = i_ribm_rdata;
        bcnt_d    = '0;
        p_state_d = P_REPLY;
      end
      default: if (i_tx_rdy) begin
        bcnt_d = bcnt_q + 2'd1;
        if (wr_q || bcnt_q == 2'd3) p_state_d = P_IDLE;
      end
    endcase
`ifdef UART_RIB_TIMEOUT_EN
    if (p_state_q == P_ADDR || p_state_q == P_DATA) begin
      if (byte_vld_q) tmo_d = '0;
      else if (tmo_q == TW'(TIMEOUT)) p_state_d = P_IDLE;
      else tmo_d = tmo_q + TW'(1);
    end
`endif
    // A broken byte only abandons a frame still being received; bus work in flight completes.
    if (frm_err_q && (p_state_q == P_IDLE || p_state_q == P_ADDR || p_state_q == P_DATA))
      p_state_d = P_IDLE;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (i_rst) begin
      rx_sync_q  <= '1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      p_state_q  <= P_IDLE;
      bcnt_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wr_q       <= 1'b0;
`ifdef UART_RIB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
      p_state_q  <= p_state_d;
      bcnt_q     <= bcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wr_q       <= wr_d;
`ifdef UART_RIB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign o_ribm_addr  = addr_q;
  assign o_ribm_wrcs  = wr_q;
  assign o_ribm_mask  = 4'hF;
  assign o_ribm_wdata = wdata_q;
  assign o_ribm_req   = (p_state_q == P_REQ);
  assign o_ribm_rdy   = (p_state_q == P_RSP);
  assign o_tx_vld     = (p_state_q == P_REPLY);
  assign o_tx_data    = wr_q ? ACK_BYTE : rdata_q[{bcnt_q, 3'b000} +: 8];
  assign o_frm_err    = frm_err_q;

endmodule

// File: tb/tb_uart_rib_master.sv
// Scoreboard bench for uart_rib_master: directed UART frames, a RIB slave model
// and a reply sink; monitors compare bus requests and reply bytes against queued expectations.
module tb_uart_rib_master;

  localparam int CLK_DIV = 8;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] ribm_addr, ribm_wdata;
  logic        ribm_wrcs, ribm_req, ribm_rdy;
  logic [3:0]  ribm_mask;
  logic [31:0] ribm_rdata = '0;
  logic        ribm_gnt = 1'b0;
  logic        ribm_rsp = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_vld, frm_err;
  logic        tx_rdy = 1'b0;

  uart_rib_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx),
    .o_ribm_addr(ribm_addr), .o_ribm_wrcs(ribm_wrcs), .o_ribm_mask(ribm_mask),
    .o_ribm_wdata(ribm_wdata), .i_ribm_rdata(ribm_rdata), .o_ribm_req(ribm_req),
    .i_ribm_gnt(ribm_gnt), .i_ribm_rsp(ribm_rsp), .o_ribm_rdy(ribm_rdy),
    .o_tx_data(tx_data), .o_tx_vld(tx_vld), .i_tx_rdy(tx_rdy), .o_frm_err(frm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          req_cycles;
  } txn_t;

  txn_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int n_cmp = 0;
  int n_err = 0;
  int frm_cnt = 0;

  // Slave / sink behaviour, set by the stimulus before each frame
  int          gnt_delay = 0;
  int          rsp_delay = 1;
  logic [31:0] slave_rdata = '0;
  int          tx_stall = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CLK_DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) tick();
    end
    rx = stop;
    repeat (CLK_DIV) tick();
    rx = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_le32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic write_frame(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    send_le32(a);
    send_le32(d);
  endtask

  task automatic read_frame(input logic [31:0] a);
    send_byte(8'h52);
    send_le32(a);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input int gd);
    txn_t t;
    t.addr = a; t.wr = 1'b1; t.wdata = d; t.req_cycles = gd + 1;
    exp_bus.push_back(t);
    exp_tx.push_back(8'h4B);
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] rd, input int gd);
    txn_t t;
    t.addr = a; t.wr = 1'b0; t.wdata = '0; t.req_cycles = gd + 1;
    exp_bus.push_back(t);
    for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check(name, 32'(exp_bus.size() + exp_tx.size()), 32'd0);
    repeat (4) tick();
  endtask

  // RIB slave model
  initial begin
    forever begin
      tick();
      if (ribm_req) begin
        repeat (gnt_delay) tick();
        ribm_gnt = 1'b1;
        tick();
        ribm_gnt = 1'b0;
        repeat (rsp_delay - 1) tick();
        ribm_rdata = slave_rdata;
        ribm_rsp   = 1'b1;
        tick();
        ribm_rsp   = 1'b0;
        ribm_rdata = '0;
      end
    end
  end

  // Reply sink with optional back-pressure
  initial begin
    int stall;
    stall = 0;
    forever begin
      tick();
      if (tx_rdy) begin
        tx_rdy = 1'b0;
        stall  = 0;
      end else if (tx_vld) begin
        if (stall >= tx_stall) tx_rdy = 1'b1;
        else stall++;
      end
    end
  end

  // Bus monitor
  initial begin
    bit          in_req, have_exp;
    int          cycles;
    txn_t        cur;
    logic [31:0] held_addr;
    in_req = 0; have_exp = 0; cycles = 0; held_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst && ribm_req) begin
        if (!in_req) begin
          in_req = 1;
          cycles = 0;
          held_addr = ribm_addr;
          if (exp_bus.size() == 0) begin
            have_exp = 0;
            n_cmp++; n_err++;
            $display("FAIL unexpected bus request: got addr %h, expected no request", ribm_addr);
          end else begin
            have_exp = 1;
            cur = exp_bus.pop_front();
            check("bus addr", ribm_addr, cur.addr);
            check("bus wrcs", 32'(ribm_wrcs), 32'(cur.wr));
            check("bus mask", 32'(ribm_mask), 32'hF);
            if (cur.wr) check("bus wdata", ribm_wdata, cur.wdata);
          end
        end else begin
          check("bus addr held", ribm_addr, held_addr);
        end
        cycles++;
        if (ribm_gnt) begin
          in_req = 0;
          if (have_exp) check("req cycles", 32'(cycles), 32'(cur.req_cycles));
        end
      end
    end
  end

  // Reply monitor
  initial begin
    logic       p_vld, p_rdy;
    logic [7:0] p_data;
    p_vld = 0; p_rdy = 0; p_data = '0;
    forever begin
      @(negedge clk);
      if (tx_vld) begin
        if (p_vld && !p_rdy) check("tx data held", 32'(tx_data), 32'(p_data));
        if (tx_rdy) begin
          if (exp_tx.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected reply byte: got %h, expected none", tx_data);
          end else begin
            check("tx byte", 32'(tx_data), 32'(exp_tx.pop_front()));
          end
        end
      end
      p_vld = tx_vld; p_rdy = tx_rdy; p_data = tx_data;
    end
  end

  // Framing-error pulse counter
  initial forever begin
    @(negedge clk);
    if (frm_err) frm_cnt++;
  end

  // Watchdog
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish within 60000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst req",    32'(ribm_req),   32'd0);
    check("rst rdy",    32'(ribm_rdy),   32'd0);
    check("rst wrcs",   32'(ribm_wrcs),  32'd0);
    check("rst mask",   32'(ribm_mask),  32'hF);
    check("rst addr",   ribm_addr,       32'd0);
    check("rst wdata",  ribm_wdata,      32'd0);
    check("rst tx_vld", 32'(tx_vld),     32'd0);
    check("rst tx_data", 32'(tx_data),   32'd0);
    check("rst frm_err", 32'(frm_err),   32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Write, grant in the request cycle, response one cycle later
    gnt_delay = 0; rsp_delay = 1;
    expect_write(32'h0000_1000, 32'hDEAD_BEEF, 0);
    write_frame(32'h0000_1000, 32'hDEAD_BEEF);
    drain("write drain");

    // Read with grant delayed 3 cycles
    gnt_delay = 3; rsp_delay = 1; slave_rdata = 32'h1234_5678;
    expect_read(32'h1000_0008, 32'h1234_5678, 3);
    read_frame(32'h1000_0008);
    drain("read drain");

    // Read with reply back-pressure
    gnt_delay = 1; rsp_delay = 2; slave_rdata = 32'h0102_0304; tx_stall = 5;
    expect_read(32'h4000_0010, 32'h0102_0304, 1);
    read_frame(32'h4000_0010);
    drain("backpressure drain");
    tx_stall = 0;
    check("idle after reply", 32'(tx_vld), 32'd0);

    // Junk, then a stop-bit error mid-address, then a clean write
    gnt_delay = 0; rsp_delay = 1;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h12, 1'b0);
    repeat (4 * CLK_DIV) tick();
    check("frm_err pulses", 32'(frm_cnt), 32'd1);
    check("no req after frm_err", 32'(ribm_req), 32'd0);
    expect_write(32'h2000_0004, 32'h1122_3344, 0);
    write_frame(32'h2000_0004, 32'h1122_3344);
    drain("recovery drain");

    // Short low glitch on the line decodes nothing
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (12 * CLK_DIV) tick();
    check("glitch frm_err", 32'(frm_cnt), 32'd1);
    check("glitch no reply", 32'(tx_vld), 32'd0);
    slave_rdata = 32'hCAFE_F00D;
    expect_read(32'h0000_003C, 32'hCAFE_F00D, 0);
    read_frame(32'h0000_003C);
    drain("post-glitch drain");

`ifdef UART_RIB_TIMEOUT_EN
    // Abandoned frame times out; the next one runs normally
    send_byte(8'h52);
    send_byte(8'h08);
    repeat (150) tick();
    check("timeout no req", 32'(ribm_req), 32'd0);
    slave_rdata = 32'hA5B6_C7D8;
    expect_read(32'h3000_000C, 32'hA5B6_C7D8, 0);
    read_frame(32'h3000_000C);
    drain("timeout drain");
`endif

    repeat (20) tick();
    check("final req", 32'(ribm_req), 32'd0);
    check("final tx_vld", 32'(tx_vld), 32'd0);
    check("final frm_err count", 32'(frm_cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rib_master.md
Name: uart_rib_master

Overview:
- Debug/loader bus initiator. Deserialises command frames from a UART RX line and issues single-word RIB transactions as master. Returns results over a byte stream to an external UART transmitter.
- Sits between the host serial pin and the RIB interconnect, alongside CPU master ports. Used to load memory and peek/poke peripherals without the core running.

Parameters:
- CLK_DIV, 868, i_clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- TIMEOUT, 1000000, inter-byte idle cycles before an incomplete frame is discarded (UART_RIB_TIMEOUT_EN only).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_rx  in  1  UART serial input; idle high; asynchronous to i_clk
- o_ribm_addr  out  32  RIB address
- o_ribm_wrcs  out  1  1 = write, 0 = read
- o_ribm_mask  out  4  byte mask; always 4'b1111
- o_ribm_wdata  out  32  write data
- i_ribm_rdata  in  32  read data; valid when i_ribm_rsp=1
- o_ribm_req  out  1  request
- i_ribm_gnt  in  1  grant
- i_ribm_rsp  in  1  response
- o_ribm_rdy  out  1  master ready for response
- o_tx_data  out  8  reply byte
- o_tx_vld  out  1  reply byte valid
- i_tx_rdy  in  1  downstream accepts byte
- o_frm_err  out  1  one-cycle pulse on UART stop-bit error

Behaviour:
- Reset: i_rst is synchronous, active-high; clock is i_clk. All outputs are 0 at reset, except o_ribm_mask=4'hF. The parser is in IDLE and the RX synchroniser is preset to 1.
- UART RX:
  - i_rx passes through a 2-flop synchroniser.
  - A falling edge while RX is idle starts a bit counter. The start bit is resampled at CLK_DIV/2; if it reads high, the event is a glitch and RX returns to idle.
  - 8 data bits are sampled every CLK_DIV cycles, LSB first, then the stop bit.
  - Stop bit = 1: the byte is presented to the parser with a one-cycle byte_vld.
  - Stop bit = 0: the byte is dropped, o_frm_err pulses, and the parser is forced to IDLE.
- Frame format (multi-byte fields little-endian):
  - 0x57 'W', addr[4], data[4] gives a write.
  - 0x52 'R', addr[4] gives a read.
  - Any other byte in IDLE is silently ignored.
- Parser FSM states: IDLE, ADDR (byte cnt 0..3), DATA (cnt 0..3, write only), REQ, RSP, REPLY.
  - IDLE → ADDR on a valid command byte.
  - ADDR → DATA (write) or REQ (read) after the 4th address byte.
  - DATA → REQ after the 4th data byte.
- RIB master handshake:
  - REQ: o_ribm_req=1 with addr/wrcs/wdata held stable. In the cycle i_ribm_gnt=1 is sampled, the transaction is accepted: req drops to 0 next cycle and the FSM goes to RSP.
  - RSP: o_ribm_rdy=1. In the cycle i_ribm_rsp=1, i_ribm_rdata is captured (reads), rdy drops, and the FSM goes to REPLY.
  - A rsp arriving in the same cycle req is dropped is legal and must be taken.
  - No request is issued while a prior transaction is outstanding.
- REPLY:
  - Write: one byte 0x4B 'K'.
  - Read: 4 bytes of rdata, LSB first.
  - Each byte uses valid/ready: o_tx_data is stable while o_tx_vld=1 and i_tx_rdy=0. A byte transfers when o_tx_vld & i_tx_rdy. After the last byte the FSM returns to IDLE.
- Bytes arriving outside IDLE/ADDR/DATA (during REQ/RSP/REPLY) are dropped. The host must wait for the reply.
- Minimum latency: last frame byte to o_ribm_req is 1 cycle; accepted rsp to first o_tx_vld is 1 cycle.
- Reset mid-transaction: all state clears immediately. Any outstanding RIB response after reset is ignored (rdy=0).

Optional Feature:
- Macro UART_RIB_TIMEOUT_EN.
- Defined: a counter runs while in ADDR or DATA. It clears on each received byte. Reaching TIMEOUT returns the FSM to IDLE with no bus activity and no reply. Counter width is $clog2(TIMEOUT+1).
- Undefined: no counter; the parser waits indefinitely for the remaining frame bytes.

Test Plan:
- Write frame 57 00 10 00 00 EF BE AD DE, gnt same cycle as req, rsp 1 cycle later → one txn addr=0x00001000, wrcs=1, wdata=0xDEADBEEF, mask=F; reply byte 0x4B.
- Read frame 52 08 00 00 10, slave returns rdata=0x12345678 with gnt delayed 3 cycles → req held with stable addr 0x10000008 for 4 cycles; reply bytes 78 56 34 12.
- Reply back-pressure: i_tx_rdy low for 5 cycles per byte on a read → each byte held stable; exactly 4 transfers; FSM then in IDLE.
- Junk 0x00 0xFF before a write frame, then a stop-bit-0 byte mid-address → junk ignored; o_frm_err pulses once; no bus txn; the next clean frame executes correctly.
- 2-cycle low glitch on i_rx → no byte is decoded and no o_frm_err pulse.
- With UART_RIB_TIMEOUT_EN, TIMEOUT=100: send 52 08 then idle 150 cycles, then a full read frame → first frame discarded with no req; second read executes normally.
